wishbone_rr_arbiter: RTL and testbench

WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

---
 rtl/wishbone_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// Shared-bus Wishbone arbiter: grants one of NUM_MASTERS requesters, round-robin or
// fixed priority, with optional hold-time preemption that only hands off on an ACK boundary.
module wishbone_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PRIO_MODE   = 0,
  parameter int MAX_HOLD    = 16,
  localparam int GNT_W      = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
  localparam int HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_MASTERS-1:0] CYC_I,
  input  logic                   ACK_I,
  output logic [GNT_W-1:0]       GNT,
  output logic [NUM_MASTERS-1:0] GNT_mux,
  output logic                   CYC,
  output logic                   PREEMPT,
  output logic                   dbg_state
);

  // Handshake: CYC_I[i] is master i's request and stays high for as long as it wants
  // the bus; ownership is granted via GNT_mux, and ACK_I marks the end of each transfer.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [HOLD_W-1:0]      HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [GNT_W-1:0]       PTR_RST  = GNT_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  state_t            state_q, state_d;
  logic [GNT_W-1:0]  gnt_q, gnt_d;
  logic [GNT_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic [GNT_W-1:0]       win_all, win_excl, scan_idx;
  logic                   found_all, found_excl;
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   preempt_ok;

  assign owner_onehot = ONE_HOT0 << gnt_q;

  // The search pointer is kept apart from GNT so the first search after reset starts at 0
  // while GNT itself resets to 0; afterwards it always equals the last granted index.
  always_comb begin
    win_all    = '0;
    win_excl   = '0;
    found_all  = 1'b0;
    found_excl = 1'b0;
    scan_idx   = '0;
    if (PRIO_MODE == 0) begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        scan_idx = GNT_W'((int'(ptr_q) + i) % NUM_MASTERS);
        if (CYC_I[scan_idx] && !found_all) begin
          found_all = 1'b1;
          win_all   = scan_idx;
        end
        if ((i != NUM_MASTERS) && CYC_I[scan_idx] && !found_excl) begin
          found_excl = 1'b1;
          win_excl   = scan_idx;
        end
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        scan_idx = GNT_W'(i);
        if (CYC_I[scan_idx]) begin
          found_all = 1'b1;
          win_all   = scan_idx;
        end
        if (CYC_I[scan_idx] && (scan_idx != gnt_q)) begin
          found_excl = 1'b1;
          win_excl   = scan_idx;
        end
      end
    end
  end

  assign preempt_ok = (MAX_HOLD > 0) && (hold_q == HOLD_MAX) && ACK_I &&
                      CYC_I[gnt_q] && (|(CYC_I & ~owner_onehot));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_all) begin
          state_d = BUSY;
          gnt_d   = win_all;
          ptr_d   = win_all;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (!CYC_I[gnt_q]) begin
          // Owner released: hand straight over to the next requester, or park in IDLE.
          if (found_all) begin
            gnt_d  = win_all;
            ptr_d  = win_all;
            hold_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (preempt_ok) begin
          gnt_d     = win_excl;
          ptr_d     = win_excl;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign GNT       = gnt_q;
  assign GNT_mux   = (state_q == BUSY) ? owner_onehot : '0;
  assign CYC       = (state_q == BUSY) && CYC_I[gnt_q];
  assign PREEMPT   = preempt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: a round-robin instance and a fixed-priority
// instance (both NUM_MASTERS=4, MAX_HOLD=4) with hand-computed expectations.
module tb_wishbone_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] cyc_rr, cyc_fx;
  logic       ack_rr, ack_fx;
  logic [1:0] gnt_rr, gnt_fx;
  logic [3:0] mux_rr, mux_fx;
  logic       cyc_o_rr, cyc_o_fx;
  logic       pre_rr, pre_fx;
  logic       st_rr, st_fx;

  int n_vec;
  int n_err;

  wishbone_rr_arbiter #(.NUM_MASTERS(4), .PRIO_MODE(0), .MAX_HOLD(4)) u_rr (
    .CLK(clk), .RST_N(rst_n), .CYC_I(cyc_rr), .ACK_I(ack_rr), .GNT(gnt_rr),
    .GNT_mux(mux_rr), .CYC(cyc_o_rr), .PREEMPT(pre_rr), .dbg_state(st_rr)
  );

  wishbone_rr_arbiter #(.NUM_MASTERS(4), .PRIO_MODE(1), .MAX_HOLD(4)) u_fx (
    .CLK(clk), .RST_N(rst_n), .CYC_I(cyc_fx), .ACK_I(ack_fx), .GNT(gnt_fx),
    .GNT_mux(mux_fx), .CYC(cyc_o_fx), .PREEMPT(pre_fx), .dbg_state(st_fx)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc_rr = 4'b0000; cyc_fx = 4'b0000; ack_rr = 1'b0; ack_fx = 1'b0;
    step(2);
    n_vec++; if (gnt_rr !== 2'd0) begin n_err++; $display("FAIL reset_gnt: got %0d expected 0", gnt_rr); end
    n_vec++; if (mux_rr !== 4'b0000) begin n_err++; $display("FAIL reset_mux: got %b expected 0000", mux_rr); end
    n_vec++; if (cyc_o_rr !== 1'b0 || pre_rr !== 1'b0 || st_rr !== 1'b0) begin n_err++; $display("FAIL reset_outs: cyc=%b pre=%b st=%b expected 0 0 0", cyc_o_rr, pre_rr, st_rr); end
    cyc_rr = 4'b1111;
    step(1);
    n_vec++; if (st_rr !== 1'b0 || mux_rr !== 4'b0000) begin n_err++; $display("FAIL reset_held: st=%b mux=%b expected 0 0000", st_rr, mux_rr); end
    cyc_rr = 4'b0000;
    #2 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    cyc_rr = 4'b0100;
    step(1);
    n_vec++; if (gnt_rr !== 2'd2) begin n_err++; $display("FAIL single_gnt: got %0d expected 2", gnt_rr); end
    n_vec++; if (mux_rr !== 4'b0100) begin n_err++; $display("FAIL single_mux: got %b expected 0100", mux_rr); end
    n_vec++; if (cyc_o_rr !== 1'b1) begin n_err++; $display("FAIL single_cyc: got %b expected 1", cyc_o_rr); end
    cyc_rr = 4'b0000;
    #1;
    n_vec++; if (cyc_o_rr !== 1'b0) begin n_err++; $display("FAIL single_cyc_drop: got %b expected 0", cyc_o_rr); end
    step(1);
    n_vec++; if (st_rr !== 1'b0 || mux_rr !== 4'b0000) begin n_err++; $display("FAIL single_idle: st=%b mux=%b expected 0 0000", st_rr, mux_rr); end
    n_vec++; if (gnt_rr !== 2'd2) begin n_err++; $display("FAIL single_park: got %0d expected 2", gnt_rr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] drop;
    logic [3:0] exp_mux;
    reset_pulse();
    cyc_rr = 4'b1111;
    step(1);
    n_vec++; if (gnt_rr !== 2'd0) begin n_err++; $display("FAIL b2b_first: got %0d expected 0", gnt_rr); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      drop = 4'b0001 << k;
      cyc_rr = 4'b1111 & ~drop;
      step(1);
      exp_mux = 4'b0001 << ((k + 1) % 4);
      n_vec++; if (gnt_rr !== 2'((k + 1) % 4) || st_rr !== 1'b1) begin n_err++; $display("FAIL b2b_handoff%0d: gnt=%0d st=%b expected %0d 1", k, gnt_rr, st_rr, (k + 1) % 4); end
      n_vec++; if (mux_rr !== exp_mux) begin n_err++; $display("FAIL b2b_mux%0d: got %b expected %b", k, mux_rr, exp_mux); end
      cyc_rr = 4'b1111;
    end
    cyc_rr = 4'b0000;
    step(1);
    n_vec++; if (st_rr !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", st_rr); end
  endtask

  task automatic test_rr_pointer();
    cyc_rr = 4'b0010;
    step(1);
    n_vec++; if (gnt_rr !== 2'd1) begin n_err++; $display("FAIL ptr_own1: got %0d expected 1", gnt_rr); end
    cyc_rr = 4'b1001;
    step(1);
    n_vec++; if (gnt_rr !== 2'd3 || mux_rr !== 4'b1000) begin n_err++; $display("FAIL ptr_wrap: gnt=%0d mux=%b expected 3 1000", gnt_rr, mux_rr); end
    cyc_rr = 4'b0000;
    step(1);
  endtask

  task automatic test_preempt();
    int bad;
    cyc_rr = 4'b0011; ack_rr = 1'b1;
    step(1);
    n_vec++; if (gnt_rr !== 2'd0) begin n_err++; $display("FAIL pre_own0: got %0d expected 0", gnt_rr); end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (gnt_rr !== 2'd0 || pre_rr !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL pre_early: got %0d bad cycles expected 0", bad); end
    step(1);
    n_vec++; if (gnt_rr !== 2'd1 || pre_rr !== 1'b1) begin n_err++; $display("FAIL pre_fire: gnt=%0d pre=%b expected 1 1", gnt_rr, pre_rr); end
    step(1);
    n_vec++; if (gnt_rr !== 2'd1 || pre_rr !== 1'b0) begin n_err++; $display("FAIL pre_pulse: gnt=%0d pre=%b expected 1 0", gnt_rr, pre_rr); end
    cyc_rr = 4'b0001;
    step(1);
    n_vec++; if (gnt_rr !== 2'd0) begin n_err++; $display("FAIL pre_reenter: got %0d expected 0", gnt_rr); end
    cyc_rr = 4'b0011; ack_rr = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (gnt_rr !== 2'd0 || pre_rr !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL pre_noack: got %0d bad cycles expected 0", bad); end
    ack_rr = 1'b1;
    step(1);
    n_vec++; if (gnt_rr !== 2'd1 || pre_rr !== 1'b1) begin n_err++; $display("FAIL pre_sat: gnt=%0d pre=%b expected 1 1", gnt_rr, pre_rr); end
    cyc_rr = 4'b0000;
    step(2);
    cyc_rr = 4'b0100;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (gnt_rr !== 2'd2 || st_rr !== 1'b1 || pre_rr !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL pre_alone: got %0d bad cycles expected 0", bad); end
    cyc_rr = 4'b0000; ack_rr = 1'b0;
    step(1);
  endtask

  task automatic test_fixed();
    cyc_fx = 4'b0001;
    step(1);
    n_vec++; if (gnt_fx !== 2'd0) begin n_err++; $display("FAIL fix_own0: got %0d expected 0", gnt_fx); end
    cyc_fx = 4'b1010;
    step(1);
    n_vec++; if (gnt_fx !== 2'd1) begin n_err++; $display("FAIL fix_first: got %0d expected 1", gnt_fx); end
    cyc_fx = 4'b0000;
    step(1);
    cyc_fx = 4'b1010;
    step(1);
    n_vec++; if (gnt_fx !== 2'd1 || mux_fx !== 4'b0010) begin n_err++; $display("FAIL fix_repeat: gnt=%0d mux=%b expected 1 0010", gnt_fx, mux_fx); end
    ack_fx = 1'b1;
    step(5);
    n_vec++; if (gnt_fx !== 2'd3 || pre_fx !== 1'b1) begin n_err++; $display("FAIL fix_preempt: gnt=%0d pre=%b expected 3 1", gnt_fx, pre_fx); end
    cyc_fx = 4'b0000; ack_fx = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid_busy();
    cyc_rr = 4'b0011; ack_rr = 1'b1;
    step(6);
    n_vec++; if (gnt_rr !== 2'd1 || pre_rr !== 1'b1) begin n_err++; $display("FAIL rst_setup: gnt=%0d pre=%b expected 1 1", gnt_rr, pre_rr); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (mux_rr !== 4'b0000 || cyc_o_rr !== 1'b0 || pre_rr !== 1'b0) begin n_err++; $display("FAIL rst_async: mux=%b cyc=%b pre=%b expected 0000 0 0", mux_rr, cyc_o_rr, pre_rr); end
    n_vec++; if (gnt_rr !== 2'd0 || st_rr !== 1'b0) begin n_err++; $display("FAIL rst_async_gnt: gnt=%0d st=%b expected 0 0", gnt_rr, st_rr); end
    cyc_rr = 4'b1111; ack_rr = 1'b0;
    step(1);
    #2 rst_n = 1'b1;
    step(1);
    n_vec++; if (gnt_rr !== 2'd0 || st_rr !== 1'b1) begin n_err++; $display("FAIL rst_rearb: gnt=%0d st=%b expected 0 1", gnt_rr, st_rr); end
    cyc_rr = 4'b0000;
    step(1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_pointer();
    test_preempt();
    test_fixed();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
